// File: rtl/jt900h_pkg.sv
// Shared definitions for the TLCS-900H bus controller: FSM encoding,
// parameter defaults and the byte-lane merge used by the write-through path.
package jt900h_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0]  TOUT_DEF    = 8'd255;
    localparam logic [15:0] ERRDATA_DEF = 16'hFFFF;

    function automatic logic [15:0] lane_merge(
        input logic [15:0] old,
        input logic [15:0] wdata,
        input logic [1:0]  we
    );
        return {we[1] ? wdata[15:8] : old[15:8],
                we[0] ? wdata[7:0]  : old[7:0]};
    endfunction

endpackage

// File: rtl/jt900h_bus_tout.sv
// Bus watchdog: counts cen-qualified ACCESS cycles and flags the one in
// which the TOUT-th cycle elapses without the counter having been cleared.
module jt900h_bus_tout #(
    parameter logic [7:0] TOUT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic count,
    output logic expire
);

    logic [7:0] cnt;

    // expire fires during the cycle that would bring the count up to TOUT
    assign expire = count && (cnt == TOUT - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (count && !expire)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/jt900h_busctl.sv
// CPU-side bus controller: one-word read buffer with write-through merge,
// single outstanding external access, CPU stall via gated cen and a watchdog.
module jt900h_busctl
    import jt900h_pkg::*;
#(
    parameter logic [7:0]  TOUT    = TOUT_DEF,
    parameter logic [15:0] ERRDATA = ERRDATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    output logic        cpu_cen,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_we,
    output logic [15:0] cpu_din,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic [1:0]  bus_we,
    output logic        bus_req,
    input  logic        bus_ack,
    input  logic [15:0] bus_din,
    input  logic        flush,
    input  logic        err_clr,
    output logic        bus_err
);

    state_t      state;
    logic [22:0] tag;
    logic        valid;
    logic [15:0] data;
    logic        wr_done;

    logic        hit;
    logic        start;
    logic        ack;
    logic        expire;
    logic        done;
    logic [15:0] rdata;

    assign hit     = (state == IDLE) && valid && (tag == cpu_addr[23:1]) && (cpu_we == 2'b00);
    assign cpu_cen = cen && (state == IDLE) && (hit || wr_done);
    assign cpu_din = data;

    // No new access while the CPU is still consuming a completed write
    assign start = cen && (state == IDLE) && !wr_done && ((cpu_we != 2'b00) || !hit);
    assign ack   = cen && (state == ACCESS) && bus_ack;
    assign done  = ack || expire;
    assign rdata = ack ? bus_din : ERRDATA;

    jt900h_bus_tout #(.TOUT(TOUT)) u_tout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .count  (cen && (state == ACCESS)),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            bus_we   <= 2'b00;
            bus_addr <= 23'd0;
            bus_dout <= 16'd0;
            tag      <= 23'd0;
            valid    <= 1'b0;
            data     <= 16'd0;
            wr_done  <= 1'b0;
            bus_err  <= 1'b0;
        end else if (cen) begin
            if (flush)
                valid <= 1'b0;
            if (err_clr)
                bus_err <= 1'b0;
            if (expire && !bus_ack)
                bus_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (wr_done) begin
                        wr_done <= 1'b0;
                    end else if (start) begin
                        bus_addr <= cpu_addr[23:1];
                        bus_we   <= cpu_we;
                        if (cpu_we != 2'b00)
                            bus_dout <= cpu_dout;
                        bus_req  <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        bus_req <= 1'b0;
                        state   <= IDLE;
                        if (bus_we == 2'b00) begin
                            // fresh read data re-validates even against a same-cycle flush
                            data  <= rdata;
                            tag   <= bus_addr;
                            valid <= 1'b1;
                        end else begin
                            wr_done <= 1'b1;
                            if (valid && (tag == bus_addr))
                                data <= lane_merge(data, bus_dout, bus_we);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_busctl.sv
// Scoreboard bench: a CPU driver walks a directed op table, a bus responder
// acks after a programmed delay, and a negedge monitor checks each CPU release.
module tb_jt900h_busctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        cpu_cen;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_din;
    logic [22:0] bus_addr;
    logic [15:0] bus_dout;
    logic [1:0]  bus_we;
    logic        bus_req;
    logic        bus_ack;
    logic [15:0] bus_din;
    logic        flush;
    logic        err_clr;
    logic        bus_err;

    always #5 clk = ~clk;

    jt900h_busctl #(.TOUT(8'd4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .cpu_cen  (cpu_cen),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_we   (cpu_we),
        .cpu_din  (cpu_din),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_we   (bus_we),
        .bus_req  (bus_req),
        .bus_ack  (bus_ack),
        .bus_din  (bus_din),
        .flush    (flush),
        .err_clr  (err_clr),
        .bus_err  (bus_err)
    );

    typedef struct {
        int          idx;
        logic [1:0]  we;
        logic [23:0] addr;
        logic [15:0] dout;
        int          fl_cyc;
        int          ec_cyc;
        int          delay;
        logic [15:0] bdata;
        int          nreq;
        logic [22:0] baddr;
        int          stall;
        logic [15:0] din;
        logic        err;
    } op_t;

    op_t ops[$];
    op_t exp_q[$];
    op_t e;

    int vecs = 0;
    int errs = 0;
    int resp_delay = 0;
    logic [15:0] resp_data = 16'd0;
    logic inj_ack = 1'b0;
    logic mon_en = 1'b0;
    logic req_prev = 1'b0;
    int mon_stall = 0;
    int mon_nreq = 0;
    int wcnt = 0;
    logic aborted = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [1:0] we, input logic [23:0] addr, input logic [15:0] dout,
                               input int fl, input int ec, input int dly, input logic [15:0] bdata,
                               input int nreq, input logic [22:0] baddr, input int stall,
                               input logic [15:0] din, input logic err);
        op_t o;
        o.idx = 0; o.we = we; o.addr = addr; o.dout = dout; o.fl_cyc = fl; o.ec_cyc = ec;
        o.delay = dly; o.bdata = bdata; o.nreq = nreq; o.baddr = baddr; o.stall = stall;
        o.din = din; o.err = err;
        return o;
    endfunction

    // Bus responder: acks resp_delay cycles into a request (0 = never)
    initial begin
        bus_ack = 1'b0;
        bus_din = 16'd0;
        forever begin
            @(posedge clk); #1;
            bus_ack = inj_ack;
            if (inj_ack) bus_din = 16'hBEEF;
            if (bus_req) begin
                wcnt++;
                if (wcnt == resp_delay) begin
                    bus_ack = 1'b1;
                    bus_din = resp_data;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (bus_req) begin
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL bus_req_unexpected: got 1 expected 0");
                end else begin
                    if (!req_prev) mon_nreq++;
                    chk($sformatf("op%0d_bus_addr", exp_q[0].idx), {9'd0, bus_addr}, {9'd0, exp_q[0].baddr});
                    chk($sformatf("op%0d_bus_we", exp_q[0].idx), {30'd0, bus_we}, {30'd0, exp_q[0].we});
                    if (exp_q[0].we != 2'b00)
                        chk($sformatf("op%0d_bus_dout", exp_q[0].idx), {16'd0, bus_dout}, {16'd0, exp_q[0].dout});
                end
            end
            if (cpu_cen) begin
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL cpu_cen_spurious: got 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d_stall", e.idx), mon_stall, e.stall);
                    chk($sformatf("op%0d_nreq", e.idx), mon_nreq, e.nreq);
                    chk($sformatf("op%0d_cpu_din", e.idx), {16'd0, cpu_din}, {16'd0, e.din});
                    chk($sformatf("op%0d_bus_err", e.idx), {31'd0, bus_err}, {31'd0, e.err});
                end
                mon_stall = 0;
                mon_nreq = 0;
            end else if (cen && exp_q.size() != 0) begin
                mon_stall++;
            end
        end
        req_prev = bus_req;
    end

    task automatic run_op(input op_t o);
        int c;
        logic acc;
        resp_delay = o.delay;
        resp_data  = o.bdata;
        exp_q.push_back(o);
        cpu_we   = o.we;
        cpu_addr = o.addr;
        cpu_dout = o.dout;
        cen      = 1'b1;
        c = 1;
        acc = 1'b0;
        while (!acc && c <= 60) begin
            flush   = (o.fl_cyc == c);
            err_clr = (o.ec_cyc == c);
            @(negedge clk);
            acc = cpu_cen;
            @(posedge clk); #1;
            c++;
        end
        flush   = 1'b0;
        err_clr = 1'b0;
        cen     = 1'b0;
        if (!acc) begin
            errs++;
            $display("FAIL op%0d_timeout: got no cpu_cen expected release within 60 cycles", o.idx);
            aborted = 1'b1;
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0; cen = 1'b1; cpu_addr = 24'd0; cpu_dout = 16'd0; cpu_we = 2'b00;
        flush = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_cen", {31'd0, cpu_cen}, 32'd0);
        chk("rst_cpu_din", {16'd0, cpu_din}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", {9'd0, bus_addr}, 32'd0);
        chk("rst_bus_dout", {16'd0, bus_dout}, 32'd0);
        chk("rst_bus_we", {30'd0, bus_we}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        cen = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        //           we     addr        dout     fl ec dly bdata    nreq baddr       stall din      err
        ops.push_back(mk(2'b00, 24'h000100, 16'h0000, 0, 0, 3, 16'h1234, 1, 23'h000080, 4, 16'h1234, 1'b0));
        ops.push_back(mk(2'b00, 24'h000101, 16'h0000, 0, 0, 0, 16'h0000, 0, 23'h000000, 0, 16'h1234, 1'b0));
        ops.push_back(mk(2'b01, 24'h000100, 16'hAB55, 0, 0, 1, 16'h0000, 1, 23'h000080, 2, 16'h1255, 1'b0));
        ops.push_back(mk(2'b00, 24'h000100, 16'h0000, 0, 0, 0, 16'h0000, 0, 23'h000000, 0, 16'h1255, 1'b0));
        ops.push_back(mk(2'b10, 24'h000300, 16'h77AA, 0, 0, 2, 16'h0000, 1, 23'h000180, 3, 16'h1255, 1'b0));
        ops.push_back(mk(2'b00, 24'h000100, 16'h0000, 0, 0, 0, 16'h0000, 0, 23'h000000, 0, 16'h1255, 1'b0));
        ops.push_back(mk(2'b11, 24'h000101, 16'hCAFE, 1, 0, 1, 16'h0000, 1, 23'h000080, 2, 16'h1255, 1'b0));
        ops.push_back(mk(2'b00, 24'h000100, 16'h0000, 2, 0, 1, 16'h5A5A, 1, 23'h000080, 2, 16'h5A5A, 1'b0));
        ops.push_back(mk(2'b00, 24'h000100, 16'h0000, 0, 0, 0, 16'h0000, 0, 23'h000000, 0, 16'h5A5A, 1'b0));
        ops.push_back(mk(2'b00, 24'h000400, 16'h0000, 0, 0, 0, 16'h0000, 1, 23'h000200, 5, 16'hFFFF, 1'b1));
        ops.push_back(mk(2'b00, 24'h000400, 16'h0000, 0, 1, 0, 16'h0000, 0, 23'h000000, 0, 16'hFFFF, 1'b1));
        ops.push_back(mk(2'b00, 24'h000401, 16'h0000, 0, 0, 0, 16'h0000, 0, 23'h000000, 0, 16'hFFFF, 1'b0));
        ops.push_back(mk(2'b00, 24'h000500, 16'h0000, 0, 0, 4, 16'h0F0F, 1, 23'h000280, 5, 16'h0F0F, 1'b0));
        ops.push_back(mk(2'b00, 24'h000600, 16'h0000, 0, 0, 3, 16'h1111, 1, 23'h000300, 4, 16'h1111, 1'b0));
        ops.push_back(mk(2'b11, 24'h000700, 16'h2222, 0, 0, 0, 16'h0000, 1, 23'h000380, 5, 16'h1111, 1'b1));
        ops.push_back(mk(2'b00, 24'h000601, 16'h0000, 0, 1, 0, 16'h0000, 0, 23'h000000, 0, 16'h1111, 1'b1));
        ops.push_back(mk(2'b00, 24'h000600, 16'h0000, 0, 0, 0, 16'h0000, 0, 23'h000000, 0, 16'h1111, 1'b0));

        foreach (ops[i]) begin
            if (!aborted) begin
                ops[i].idx = i + 1;
                run_op(ops[i]);
            end
        end

        if (!aborted) begin
            @(posedge clk); #1;
            chk("queue_drained", exp_q.size(), 32'd0);
            mon_en = 1'b0;

            // Reset in the middle of a read, then an orphan ack after release
            resp_delay = 0;
            cpu_addr = 24'h000200; cpu_we = 2'b00; cen = 1'b1;
            k = 0;
            while (!bus_req && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid_req_seen", {31'd0, bus_req}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("rst_mid_bus_req", {31'd0, bus_req}, 32'd0);
            chk("rst_mid_cpu_din", {16'd0, cpu_din}, 32'd0);
            chk("rst_mid_bus_addr", {9'd0, bus_addr}, 32'd0);
            chk("rst_mid_cpu_cen", {31'd0, cpu_cen}, 32'd0);
            cen = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            inj_ack = 1'b1;
            @(posedge clk); #2;
            cen = 1'b1;
            @(negedge clk);
            inj_ack = 1'b0;
            @(negedge clk);
            chk("orphan_ack_cpu_din", {16'd0, cpu_din}, 32'd0);
            chk("orphan_ack_new_req", {31'd0, bus_req}, 32'd1);
            chk("orphan_ack_cpu_cen", {31'd0, cpu_cen}, 32'd0);
            cen = 1'b0;
            rst_n = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
